car_motion_controller: RTL

Car-side motion and door sequencer for the four-floor elevator. It receives direction, open-door and restart commands from the request memory manager and returns floor position, direction of motion, arrival interrupts (`Delay`), next-stage interrupts (`NextStageDelay`) and the idle indication (`Stop`). It times floor-to-floor travel and door dwell, and is the single source of `CurrentFloor` in the design.

---
 rtl/car_motion_controller.sv | 118 +++++++++++
 1 files changed

// File: rtl/car_motion_controller.sv
// Car-side motion and door sequencer for a four-floor elevator.
// Times floor-to-floor travel and door dwell; sole owner of CurrentFloor.
module car_motion_controller #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UDRequest,
  input  logic       OCRequest,
  input  logic       NoStopRequest,
  input  logic       DoneDelay,
  input  logic       DoneNextStageDelay,
  output logic [1:0] CurrentFloor,
  output logic       UDIn,
  output logic       Delay,
  output logic       NextStageDelay,
  output logic       Stop,
  output logic       DoorOpen,
  output logic       Moving
);

  localparam logic [7:0] TravelLast = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DoorLast   = 8'(DOOR_CYCLES - 1);
  localparam logic [7:0] NextLast   = 8'(4 * DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTravel,
    StArrive,
    StDoor,
    StNext
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic       ud_q, ud_d;
  logic [7:0] timer_q, timer_d;

  function automatic logic move_legal(logic up, logic [1:0] floor);
    return up ? (floor != 2'd3) : (floor != 2'd0);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      floor_q <= 2'd0;
      ud_q    <= 1'b0;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      ud_q    <= ud_d;
      timer_q <= timer_d;
    end
  end

  // Timer defaults to zero so every state change clears it; staying states count.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    ud_d    = ud_q;
    timer_d = 8'd0;
    unique case (state_q)
      StIdle: begin
        if (NoStopRequest) begin
          ud_d    = UDRequest;
          state_d = move_legal(UDRequest, floor_q) ? StTravel : StArrive;
        end
      end
      StTravel: begin
        if (timer_q == TravelLast) begin
          floor_d = ud_q ? floor_q + 2'd1 : floor_q - 2'd1;
          state_d = StArrive;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StArrive: begin
        // Acknowledge ignored on the first ARRIVE cycle (timer still zero).
        if (timer_q != 8'd0 && DoneDelay) begin
          if (OCRequest) begin
            state_d = StDoor;
          end else begin
            ud_d    = UDRequest;
            state_d = move_legal(UDRequest, floor_q) ? StTravel : StIdle;
          end
        end else begin
          timer_d = 8'd1;
        end
      end
      StDoor: begin
        if (timer_q == DoorLast) begin
          state_d = StNext;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StNext: begin
        if ((timer_q != 8'd0 && DoneNextStageDelay) || timer_q == NextLast) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign CurrentFloor   = floor_q;
  assign UDIn           = ud_q;
  assign Stop           = (state_q == StIdle);
  assign Moving         = (state_q == StTravel);
  assign Delay          = (state_q == StArrive);
  assign DoorOpen       = (state_q == StDoor);
  assign NextStageDelay = (state_q == StNext);

endmodule
